insn_fetch_unit: RTL and testbench
==================================

// Module: insn_fetch_unit
// PURPOSE
//  Instruction fetch stage of the two-phase multi-cycle RV32I core; sits directly upstream of control_unit.
//  Holds the PC and fetches one word from instruction memory over a req/ack handshake.
//  Latches the fetched word into the instruction register.
//  Presents opcode/func3/func7 to control_unit and advances the PC on its command: sequential PC+4 or a branch/jump target.
// PARAMETERS
//  XLEN          32            data/address width
//  RESET_PC      32'h0000_0000 PC value loaded by reset
//  NOP_INSN      32'h0000_0013 instruction register reset value (addi x0,x0,0)
//  TIMEOUT_CYC   16            fetch watchdog limit in cycles (used only with IFU_TIMEOUT_EN)
// PORTS
//  clk            in   1     core clock; all state updates on rising edge
//  reset          in   1     synchronous, active-high
//  advance        in   1     control_unit strobe: commit current insn, update PC, start next fetch
//  pc_next_sel    in   1     0: PC <= PC+4; 1: PC <= pc_target
//  pc_target      in   XLEN  branch/jump target from PC ALU
//  imem_req       out  1     fetch request
//  imem_addr      out  XLEN  fetch address (= PC)
//  imem_rdata     in   XLEN  fetched word, valid when imem_ack=1
//  imem_ack       in   1     memory response; single-cycle pulse
//  insn           out  XLEN  instruction register
//  opcode         out  7     insn[6:0]
//  func3          out  3     insn[14:12]
//  func7          out  1     insn[30]
//  pc             out  XLEN  current PC
//  pc_plus4       out  XLEN  PC+4 (JAL/JALR link value)
//  insn_valid     out  1     insn holds the word fetched from the current PC
//  fetch_fault    out  1     sticky fault flag; cleared only by reset
// BEHAVIOUR
//  Reset values (any edge with reset=1):
//   state=BOOT, pc=RESET_PC, insn=NOP_INSN.
//   imem_req=0, insn_valid=0, fetch_fault=0.
//   Reset overrides every other input, including an in-flight ack.
//  FSM states: BOOT, FETCH, VALID, FAULT.
//   BOOT:  imem_req=0. Unconditionally -> FETCH on the next edge.
//   FETCH: imem_req=1, imem_addr=pc. imem_addr is held stable while req=1.
//          On an edge with imem_ack=1: insn<=imem_rdata, -> VALID.
//          An ack arriving in the same cycle req first rises is legal, giving a minimum fetch latency of 1 cycle.
//   VALID: imem_req=0, insn_valid=1.
//          On an edge with advance=1: pc <= pc_next_sel ? pc_target : pc+4, -> FETCH.
//          insn_valid drops in the cycle after advance.
//   FAULT: imem_req=0, insn_valid=0, fetch_fault=1. Left only by reset.
//  Misalignment: an advance with pc_next_sel=1 and pc_target[1:0]!=0:
//   -> FAULT; pc is not updated; it keeps the faulting insn's address.
//  advance outside VALID (BOOT/FETCH/FAULT): ignored, no PC change.
//  imem_ack outside FETCH: ignored; insn unchanged.
//  pc+4 wraps modulo 2^XLEN; 32'hFFFF_FFFC -> 32'h0000_0000, no fault.
//  opcode/func3/func7/pc_plus4 are combinational from registers; no input-to-output combinational path.
// CONFIGURATION
//  IFU_TIMEOUT_EN defined:
//   - Watchdog counter, clog2(TIMEOUT_CYC+1) bits; cleared on entry to FETCH; increments each FETCH cycle without ack.
//   - On reaching TIMEOUT_CYC with no ack: -> FAULT.
//   - An ack on the same edge as the limit wins: the fetch completes normally.
//  IFU_TIMEOUT_EN undefined:
//   - No counter; FETCH waits for ack indefinitely.
//   - fetch_fault is set only by a misaligned target.
// TESTING
//  1 Reset then ack after 1 cycle, rdata=32'h00500093:
//     imem_req rises 1 cycle after reset drops; addr=0.
//     insn=32'h00500093, opcode=7'h13, insn_valid=1.
//  2 advance with sel=0 at pc=32'h0000_0010 -> imem_addr=32'h0000_0014, insn_valid=0 until ack.
//  3 advance with sel=1, target=32'h0000_0100 -> next req at addr 32'h0000_0100.
//     Then target=32'h0000_0102 -> fetch_fault=1, pc unchanged, req stays 0.
//  4 Reset asserted mid-FETCH with ack on the same edge:
//     pc=RESET_PC, insn=NOP_INSN, insn_valid=0.
//     Fetch of addr 0 restarts after BOOT.
//  5 Spurious inputs: advance during FETCH and ack during VALID -> no state/PC/insn change.
//     pc=32'hFFFF_FFFC with sel=0 -> pc=0.
//  6 IFU_TIMEOUT_EN, TIMEOUT_CYC=16:
//     No ack for 16 cycles -> fetch_fault=1.
//     Ack on cycle 16 -> normal VALID, no fault.

Source files
------------

// File: rtl/insn_fetch_unit.sv
// Fetch stage: holds the PC, fetches over req/ack, latches the instruction.
// Define IFU_TIMEOUT_EN to add a fetch watchdog that faults after TIMEOUT_CYC cycles.
module insn_fetch_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSN    = 'h0000_0013,
    parameter int unsigned     TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    input  logic            pc_next_sel,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ack,
    output logic [XLEN-1:0] insn,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic            func7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            insn_valid,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        VALID,
        FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] insn_q, insn_d;
    logic            misaligned;

`ifdef IFU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = |TIMEOUT_CYC;
`endif

    assign pc_plus4   = pc_q + XLEN'(4);
    assign misaligned = pc_next_sel && (pc_target[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
`ifdef IFU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
`ifdef IFU_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            FETCH: begin
                if (imem_ack) begin
                    insn_d  = imem_rdata;
                    state_d = VALID;
                end
`ifdef IFU_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            VALID: begin
`ifdef IFU_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (advance) begin
                    // A misaligned target keeps the faulting insn's PC.
                    if (misaligned) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = pc_next_sel ? pc_target : pc_plus4;
                        state_d = FETCH;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            insn_q  <= NOP_INSN;
`ifdef IFU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
`ifdef IFU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign insn        = insn_q;
    assign opcode      = insn_q[6:0];
    assign func3       = insn_q[14:12];
    assign func7       = insn_q[30];
    assign pc          = pc_q;
    assign insn_valid  = (state_q == VALID);
    assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Directed self-checking bench for insn_fetch_unit.
`timescale 1ns/1ps
module tb_insn_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance;
    logic        pc_next_sel;
    logic [31:0] pc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        insn_valid;
    logic        fetch_fault;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    insn_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .pc_next_sel (pc_next_sel),
        .pc_target   (pc_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .insn        (insn),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .insn_valid  (insn_valid),
        .fetch_fault (fetch_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_word(input logic [31:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic do_advance(input logic sel, input logic [31:0] tgt);
        advance     = 1'b1;
        pc_next_sel = sel;
        pc_target   = tgt;
        tick();
        advance     = 1'b0;
        pc_next_sel = 1'b0;
        pc_target   = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        imem_ack = 1'b0;
        n_chk++;
        if (pc !== 32'h0) $display("FAIL rst_pc got %h exp %h", pc, 32'h0);
        else n_pass++;
        n_chk++;
        if (insn !== 32'h13) $display("FAIL rst_insn got %h exp %h", insn, 32'h13);
        else n_pass++;
        n_chk++;
        if ({imem_req, insn_valid, fetch_fault} !== 3'b000)
            $display("FAIL rst_flags got %b exp 000", {imem_req, insn_valid, fetch_fault});
        else n_pass++;
    endtask

    task automatic test_first_fetch();
        reset = 1'b0;
        tick();
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL ff_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
        else n_pass++;
        ack_word(32'h0050_0093);
        n_chk++;
        if (insn !== 32'h0050_0093 || opcode !== 7'h13 || insn_valid !== 1'b1)
            $display("FAIL ff_insn got insn=%h op=%h v=%b exp 00500093/13/1", insn, opcode, insn_valid);
        else n_pass++;
        n_chk++;
        if (imem_req !== 1'b0) $display("FAIL ff_req_low got %b exp 0", imem_req);
        else n_pass++;
    endtask

    task automatic test_sequential();
        do_advance(1'b1, 32'h0000_0010);
        ack_word(32'h0000_0013);
        do_advance(1'b0, 32'h0000_0000);
        n_chk++;
        if (imem_addr !== 32'h14 || imem_req !== 1'b1 || insn_valid !== 1'b0)
            $display("FAIL seq_adv got addr=%h req=%b v=%b exp 14/1/0", imem_addr, imem_req, insn_valid);
        else n_pass++;
        tick();
        n_chk++;
        if (insn_valid !== 1'b0 || imem_req !== 1'b1)
            $display("FAIL seq_wait got v=%b req=%b exp 0/1", insn_valid, imem_req);
        else n_pass++;
        ack_word(32'h0000_0013);
        n_chk++;
        if (insn_valid !== 1'b1 || pc !== 32'h14 || pc_plus4 !== 32'h18)
            $display("FAIL seq_done got v=%b pc=%h p4=%h exp 1/14/18", insn_valid, pc, pc_plus4);
        else n_pass++;
    endtask

    task automatic test_branch_and_fault();
        do_advance(1'b1, 32'h0000_0100);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100)
            $display("FAIL br_req got req=%b addr=%h exp 1/100", imem_req, imem_addr);
        else n_pass++;
        ack_word(32'h4000_5033);
        n_chk++;
        if (opcode !== 7'h33 || func3 !== 3'd5 || func7 !== 1'b1)
            $display("FAIL br_dec got op=%h f3=%0d f7=%b exp 33/5/1", opcode, func3, func7);
        else n_pass++;
        do_advance(1'b1, 32'h0000_0102);
        n_chk++;
        if (fetch_fault !== 1'b1 || pc !== 32'h100 || imem_req !== 1'b0 || insn_valid !== 1'b0)
            $display("FAIL mis_fault got f=%b pc=%h req=%b v=%b exp 1/100/0/0",
                     fetch_fault, pc, imem_req, insn_valid);
        else n_pass++;
        do_advance(1'b0, 32'h0);
        ack_word(32'h1234_5678);
        tick();
        n_chk++;
        if (fetch_fault !== 1'b1 || pc !== 32'h100 || imem_req !== 1'b0 || insn !== 32'h4000_5033)
            $display("FAIL fault_sticky got f=%b pc=%h req=%b insn=%h exp 1/100/0/40005033",
                     fetch_fault, pc, imem_req, insn);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        ack_word(32'h0000_0013);
        do_advance(1'b1, 32'h0000_0200);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200)
            $display("FAIL rmf_pre got req=%b addr=%h exp 1/200", imem_req, imem_addr);
        else n_pass++;
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        n_chk++;
        if (pc !== 32'h0 || insn !== 32'h13 || insn_valid !== 1'b0 || fetch_fault !== 1'b0)
            $display("FAIL rmf_rst got pc=%h insn=%h v=%b f=%b exp 0/13/0/0",
                     pc, insn, insn_valid, fetch_fault);
        else n_pass++;
        reset = 1'b0;
        imem_ack = 1'b0;
        n_chk++;
        if (imem_req !== 1'b0) $display("FAIL rmf_boot got req=%b exp 0", imem_req);
        else n_pass++;
        tick();
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL rmf_restart got req=%b addr=%h exp 1/0", imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_spurious_and_wrap();
        do_advance(1'b1, 32'h0000_0300);
        n_chk++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || insn_valid !== 1'b0)
            $display("FAIL sp_adv got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, insn_valid);
        else n_pass++;
        ack_word(32'h0010_0113);
        ack_word(32'hCAFE_F00D);
        n_chk++;
        if (insn !== 32'h0010_0113 || insn_valid !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0)
            $display("FAIL sp_ack got insn=%h v=%b pc=%h req=%b exp 00100113/1/0/0",
                     insn, insn_valid, pc, imem_req);
        else n_pass++;
        do_advance(1'b1, 32'hFFFF_FFFC);
        ack_word(32'h0000_0013);
        n_chk++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0)
            $display("FAIL wrap_p4 got pc=%h p4=%h exp fffffffc/0", pc, pc_plus4);
        else n_pass++;
        do_advance(1'b0, 32'h0);
        n_chk++;
        if (pc !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1 || fetch_fault !== 1'b0)
            $display("FAIL wrap_pc got pc=%h addr=%h req=%b f=%b exp 0/0/1/0",
                     pc, imem_addr, imem_req, fetch_fault);
        else n_pass++;
    endtask

`ifdef IFU_TIMEOUT_EN
    task automatic test_timeout();
        for (int i = 0; i < 15; i++) tick();
        n_chk++;
        if (fetch_fault !== 1'b0 || imem_req !== 1'b1)
            $display("FAIL to_pre got f=%b req=%b exp 0/1", fetch_fault, imem_req);
        else n_pass++;
        tick();
        n_chk++;
        if (fetch_fault !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL to_fault got f=%b req=%b exp 1/0", fetch_fault, imem_req);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        ack_word(32'h0000_0093);
        n_chk++;
        if (fetch_fault !== 1'b0 || insn_valid !== 1'b1 || insn !== 32'h93)
            $display("FAIL to_ack got f=%b v=%b insn=%h exp 0/1/93", fetch_fault, insn_valid, insn);
        else n_pass++;
    endtask
`endif

    initial begin
        reset       = 1'b1;
        advance     = 1'b0;
        pc_next_sel = 1'b0;
        pc_target   = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch_and_fault();
        test_reset_mid_fetch();
        test_spurious_and_wrap();
`ifdef IFU_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
